// File: rtl/ram_access_master_pkg.sv
// Shared defaults and issue-FSM state type for the RAM access master slice.
package ram_access_master_pkg;

  localparam int unsigned RAM_ADDR_WIDTH = 16;
  localparam int unsigned RAM_DATA_WIDTH = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } issue_state_e;

endpackage

// File: rtl/ram_access_master_sync_fifo.sv
// Show-ahead synchronous FIFO; count carries one extra bit so full and empty are distinct.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == DEPTH_C);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign rdata     = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ram_access_master.sv
// Single-port RAM initiator: queues client commands, issues them in order and
// returns read data in order through a credit-limited response FIFO.
module ram_access_master
  import ram_access_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = RAM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = RAM_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);
  localparam int unsigned   CMD_W   = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int unsigned   CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  issue_state_e          r_state;
  issue_state_e          w_state_nxt;
  logic [CMD_W-1:0]      w_cmd_head;
  logic                  w_cmd_full;
  logic                  w_cmd_empty;
  logic                  w_cmd_push;
  logic [CW-1:0]         w_cmd_count;
  logic                  w_head_we;
  logic [ADDR_WIDTH-1:0] w_head_addr;
  logic [DATA_WIDTH-1:0] w_head_wdata;
  logic                  w_rsp_full;
  logic                  w_rsp_empty;
  logic                  w_rsp_pop;
  logic [CW-1:0]         w_rsp_count;
  logic                  w_capture;
  logic                  w_credit_ok;
  logic                  w_pop;
  logic                  w_rd_issue;
  logic [CW-1:0]         r_outstanding;
  logic [RD_LATENCY:0]   r_rd_tag;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic                  r_ram_cmd_we;
  logic [DATA_WIDTH-1:0] r_ram_wdata;

  assign cmd_ready  = rst_n && (w_cmd_count < DEPTH_C);
  assign w_cmd_push = cmd_valid && cmd_ready;

  sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_cmd_push),
    .pop   (w_pop),
    .wdata ({cmd_we, cmd_addr, cmd_wdata}),
    .rdata (w_cmd_head),
    .full  (w_cmd_full),
    .empty (w_cmd_empty),
    .count (w_cmd_count)
  );

  assign {w_head_we, w_head_addr, w_head_wdata} = w_cmd_head;

  // Reads in flight plus buffered responses may never exceed the response FIFO.
  assign w_credit_ok = ({1'b0, r_outstanding} + {1'b0, w_rsp_count}) < {1'b0, DEPTH_C};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = ST_IDLE;
    if (!w_cmd_empty && (w_head_we || w_credit_ok)) w_state_nxt = ST_ISSUE;
  end

  always_comb begin
    w_pop      = 1'b0;
    w_rd_issue = 1'b0;
    if (w_state_nxt == ST_ISSUE) begin
      w_pop      = 1'b1;
      w_rd_issue = !w_head_we;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ram_addr   <= '0;
      r_ram_cmd_we <= 1'b0;
      r_ram_wdata  <= '0;
    end else if (w_pop) begin
      r_ram_addr   <= w_head_addr;
      r_ram_cmd_we <= w_head_we;
      r_ram_wdata  <= w_head_wdata;
    end
  end

  // r_state is ISSUE exactly for the cycle a popped command sits on the port.
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign ram_we    = (r_state == ST_ISSUE) && r_ram_cmd_we;

  assign w_capture = r_rd_tag[RD_LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_tag      <= '0;
      r_outstanding <= '0;
    end else begin
      r_rd_tag <= {r_rd_tag[RD_LATENCY-1:0], w_rd_issue};
      case ({w_rd_issue, w_capture})
        2'b10:   r_outstanding <= r_outstanding + CW'(1);
        2'b01:   r_outstanding <= r_outstanding - CW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  assign w_rsp_pop = rsp_valid && rsp_ready;
  assign rsp_valid = !w_rsp_empty;

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_capture),
    .pop   (w_rsp_pop),
    .wdata (ram_rdata),
    .rdata (rsp_rdata),
    .full  (w_rsp_full),
    .empty (w_rsp_empty),
    .count (w_rsp_count)
  );

  a_no_cmd_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(w_cmd_push && w_cmd_full));
  a_no_rsp_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(w_capture && w_rsp_full));

endmodule

// File: tb/tb_ram_access_master.sv
// Randomized bench for ram_access_master with a behavioural one-cycle-latency RAM and an in-order response model.
module tb_ram_access_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          n_rsp   = 0;
  bit          acc;
  bit          rand_rdy = 1'b0;
  bit          lat_arm  = 1'b0;
  int          lat_step = -1;
  bit          we_log [4096];
  logic [31:0] ram_mem   [256];
  logic [31:0] model_mem [256];
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  ram_access_master #(
    .ADDR_WIDTH (16),
    .DATA_WIDTH (32),
    .FIFO_DEPTH (4),
    .RD_LATENCY (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  // Stand-in for one RAM port: read-first, one cycle of read latency.
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr[7:0]] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr[7:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Samples just after inputs settle, well before the next rising edge, then moves to the next falling edge.
  task automatic step();
    if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
    #1;
    acc = cmd_valid && cmd_ready;
    if (exp_q.size() == 0) check("rsp_valid_without_read", 32'(rsp_valid), 32'd0);
    else if (rsp_valid && rsp_ready) begin
      check("rsp_rdata", rsp_rdata, exp_q.pop_front());
      n_rsp++;
    end
    if (lat_arm && rsp_valid) begin
      lat_step = cyc;
      lat_arm  = 1'b0;
    end
    if (acc) begin
      if (cmd_we) model_mem[cmd_addr[7:0]] = cmd_wdata;
      else        exp_q.push_back(model_mem[cmd_addr[7:0]]);
    end
    if (cyc < 4096) we_log[cyc] = ram_we;
    @(negedge clk);
    cyc++;
  endtask

  task automatic send(input bit we, input logic [15:0] addr, input logic [31:0] data, output int acc_step);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = data;
    acc_step  = -1;
    for (int i = 0; i < 300; i++) begin
      step();
      if (acc) begin
        acc_step = cyc - 1;
        return;
      end
    end
    check("cmd_accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    rand_rdy  = 1'b0;
    rsp_ready = 1'b1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) step();
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    step();
    step();
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
    check({pfx, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({pfx, "_rsp_rdata"}, rsp_rdata, 32'd0);
    check({pfx, "_ram_addr"},  32'(ram_addr), 32'd0);
    check({pfx, "_ram_we"},    32'(ram_we), 32'd0);
    check({pfx, "_ram_wdata"}, ram_wdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, s0, s_last, s_rd0, n0;

    for (int a = 0; a < 256; a++) begin
      ram_mem[a]   = '0;
      model_mem[a] = '0;
    end
    rst_n     = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;

    // Power-on reset
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) step();
    check_reset_outputs("por");
    rst_n = 1'b1;
    step();
    step();
    check("cmd_ready_after_reset", 32'(cmd_ready), 32'd1);

    // Write then read, with first-response latency
    rsp_ready = 1'b1;
    send(1'b1, 16'd0, 32'h10, s);
    send(1'b1, 16'd2, 32'h11, s);
    lat_arm  = 1'b1;
    lat_step = -1;
    send(1'b0, 16'd0, $urandom, s_rd0);
    send(1'b0, 16'd2, $urandom, s);
    cmd_valid = 1'b0;
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) step();
    check("wr_rd_latency", 32'(lat_step - s_rd0), 32'd4);
    check("wr_rd_count", 32'(exp_q.size()), 32'd0);
    drain();

    // Reset in the middle of a burst of three reads
    send(1'b0, 16'd5, 32'hDEAD0001, s);
    send(1'b0, 16'd6, 32'hDEAD0002, s);
    send(1'b0, 16'd7, 32'hDEAD0003, s);
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    exp_q.delete();
    #1;
    check_reset_outputs("mid_rst");
    step();
    step();
    rst_n = 1'b1;
    repeat (12) step();

    // Backpressure: eight reads of a preloaded word while responses are stalled
    send(1'b1, 16'd7, 32'hAF, s);
    drain();
    rsp_ready = 1'b0;
    n0 = n_rsp;
    for (int i = 0; i < 8; i++) begin
      send(1'b0, 16'd7, $urandom, s);
      if (i == 0) s0 = s;
    end
    cmd_valid = 1'b0;
    check("bp_accept_span", 32'(s - s0), 32'd7);
    for (int i = 0; i < 4; i++) begin
      step();
      check("bp_cmd_ready_low", 32'(cmd_ready), 32'd0);
    end
    drain();
    check("bp_rsp_count", 32'(n_rsp - n0), 32'd8);

    // Throughput: alternating write/read with cmd_valid held high
    rsp_ready = 1'b1;
    s0 = 0;
    for (int i = 0; i < 8; i++) begin
      send(1'b1, 16'(i), 32'(i * 3), s);
      if (i == 0) s0 = s;
      send(1'b0, 16'(i), $urandom, s);
    end
    s_last    = s;
    cmd_valid = 1'b0;
    drain();
    check("tput_accept_span", 32'(s_last - s0), 32'd15);
    for (int j = 0; j < 16; j++)
      check("tput_ram_we_toggle", 32'(we_log[s0 + 2 + j]), 32'((j % 2) == 0));

    // Response FIFO at depth-1 with a simultaneous capture and pop
    for (int a = 0; a < 4; a++) send(1'b1, 16'(20 + a), $urandom, s);
    drain();
    rsp_ready = 1'b0;
    n0 = n_rsp;
    for (int a = 0; a < 3; a++) send(1'b0, 16'(20 + a), $urandom, s);
    cmd_valid = 1'b0;
    repeat (6) step();
    send(1'b0, 16'd23, $urandom, s);
    cmd_valid = 1'b0;
    step();
    step();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    repeat (3) begin
      step();
      check("edge_rsp_valid_held", 32'(rsp_valid), 32'd1);
    end
    drain();
    check("edge_rsp_count", 32'(n_rsp - n0), 32'd4);

    // Random traffic with random response backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 150; i++) begin
      cmd_valid = 1'b0;
      repeat ($urandom_range(0, 2)) step();
      send(1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), $urandom, s);
    end
    cmd_valid = 1'b0;
    drain();

    // Idle
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_ram_we", 32'(ram_we), 32'd0);
      check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
